lane_symbol_gen: RTL and testbench
==================================

// Module: lane_symbol_gen
// PURPOSE
// - Downstream of the channel-init FSM. Turns its ordered_sets request and init_finished flag
//   into a registered 2-byte TX symbol stream (data + K-flags) for the 8b/10b encoder.
// - Generates idle, verification and clock-compensation sequences.
// - Passes user data through once the channel is ready.
// PARAMETERS
// - A_MIN      16     minimum /A/ spacing in cycles; spacing = A_MIN + lfsr[3:0] (16..31)
// - CC_PERIOD  5000   cycles between /CC/ bursts (CLK_COMP_EN only)
// - CC_LEN     6      cycles per /CC/ burst (CLK_COMP_EN only)
// PORTS
// - clk            in   1   TX clock
// - rst            in   1   asynchronous, active-high reset
// - ordered_sets   in   3   ordered_sets_t: OS_NONE, OS_IDLE, OS_VER
// - init_finished  in   1   channel init complete; data allowed when OS_NONE
// - data_in        in   16  user data word, [15:8] sent first
// - data_valid     in   1   data_in valid
// - data_ready     out  1   block accepts data_in this cycle
// - tx_data        out  16  symbol pair to encoder
// - tx_charisk     out  2   per-byte K flag; [1] belongs to [15:8]
// BEHAVIOUR
// - Reset (async assert, sync release): tx_data=16'h0000, tx_charisk=2'b00, data_ready=0,
//   lfsr=7'h5A, a_cnt=A_MIN, state=S_RESET. Leave S_RESET on the first clock after release.
// - All outputs except data_ready are registered: 1-cycle latency from input to tx_*.
// - FSM states S_RESET, S_IDLE, S_VER, S_DATA, S_CC. Evaluated every cycle, in priority order:
//   - cc_due (CLK_COMP_EN) -> S_CC
//   - OS_VER -> S_VER
//   - OS_IDLE, or OS_NONE with !init_finished -> S_IDLE
//   - OS_NONE with init_finished -> S_DATA
// - S_IDLE:
//   - a_cnt==0: emit /A/ {K28.3,K28.3} = 16'h7C7C, charisk 2'b11; reload a_cnt = A_MIN + lfsr[3:0].
//   - Otherwise decrement a_cnt and emit /K/ {BC,BC} if lfsr[0]==0, else /R/ {1C,1C};
//     charisk 2'b11.
//   - LFSR x^7+x^6+1 advances every S_IDLE cycle only.
// - S_VER: emit /V/ = {K28.5, D21.5} = 16'hBCB5, charisk 2'b10 every cycle; a_cnt and lfsr frozen.
// - S_DATA:
//   - data_ready=1 combinationally (rst=0, state conditions met, no CC due/active).
//   - valid&&ready: next cycle tx_data=data_in, charisk=2'b00.
//   - data_valid=0: emit idle symbols exactly as in S_IDLE (LFSR/a_cnt advance).
// - data_ready=0 in every other state and during reset.
// - Request change mid-sequence takes effect next cycle; no symbol pair is ever truncated.
// - Data beats are never dropped: a beat accepted in cycle N always appears in cycle N+1, even
//   if ordered_sets changes in cycle N+1.
// - lfsr never reaches 0; a_cnt is 5 bits and saturates at 0 only through reload.
// CONFIGURATION
// - CLK_COMP_EN defined:
//   - 13-bit cc_timer counts up every cycle after reset.
//   - At CC_PERIOD-1, cc_due is raised and the timer clears.
//   - S_CC emits CC_LEN cycles of {K23.7,K23.7} = 16'hF7F7, charisk 2'b11, then re-evaluates.
//   - data_ready=0 from the cycle cc_due rises until S_CC exits.
//   - Expiry during S_VER/S_IDLE preempts them.
// - CLK_COMP_EN undefined: no timer, no S_CC; never emits F7.
// STRUCTURE
// - aurora_pkg: ordered_sets_t enum; K28_5=8'hBC, K28_3=8'h7C, K28_0=8'h1C, K23_7=8'hF7,
//   D21_5=8'hB5.
// - One sub-module: idle_seq_lfsr (lfsr + a_cnt; inputs adv; outputs sym[15:0]).
// TESTING
// - rst held 5 cycles then released with OS_IDLE -> first output /K/ or /R/; /A/ 16'h7C7C after
//   exactly 16 pairs; successive /A/ gaps always 16..31.
// - OS_VER for 10 cycles -> 10 consecutive 16'hBCB5 / 2'b10 at 1-cycle lag; data_ready stays 0.
// - OS_NONE + init_finished, data 16'h1234,16'h5678 back-to-back valid -> tx_data 1234 then 5678,
//   charisk 00, no bubbles.
// - Valid beat accepted, then OS_IDLE asserted next cycle -> beat still emitted, idle follows.
// - rst asserted mid-data burst -> outputs 0 in the same cycle (async); lfsr restarts at 7'h5A.
// - CLK_COMP_EN, CC_PERIOD=20, continuous valid -> after 20 cycles data_ready drops;
//   6 x 16'hF7F7; data resumes with no beat lost.

Source files
------------

// File: rtl/aurora_pkg.sv
// rtl/aurora_pkg.sv - shared types and 8b/10b control characters for lane_symbol_gen
package aurora_pkg;

  typedef enum logic [2:0] {
    OS_NONE = 3'd0,
    OS_IDLE = 3'd1,
    OS_VER  = 3'd2
  } ordered_sets_t;

  typedef enum logic [2:0] {
    S_RESET = 3'd0,
    S_IDLE  = 3'd1,
    S_VER   = 3'd2,
    S_DATA  = 3'd3,
    S_CC    = 3'd4
  } state_t;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] D21_5 = 8'hB5;

  function automatic logic [15:0] sym_pair(input logic [7:0] b);
    return {b, b};
  endfunction

endpackage

// File: rtl/idle_seq_lfsr.sv
// rtl/idle_seq_lfsr.sv - idle symbol source: x^7+x^6+1 LFSR picks /K/ or /R/, a_cnt spaces /A/
module idle_seq_lfsr
  import aurora_pkg::*;
#(
  parameter int A_MIN = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] sym
);

  logic [6:0] lfsr;
  logic [4:0] a_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr  <= 7'h5A;
      a_cnt <= 5'(A_MIN);
    end else if (adv) begin
      lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
      // Reload uses the pre-advance LFSR so the gap matches the symbol just chosen.
      if (a_cnt == 5'd0) a_cnt <= 5'(A_MIN) + {1'b0, lfsr[3:0]};
      else               a_cnt <= a_cnt - 5'd1;
    end
  end

  always_comb begin
    sym = sym_pair(K28_5);
    if (a_cnt == 5'd0)  sym = sym_pair(K28_3);
    else if (lfsr[0])   sym = sym_pair(K28_0);
  end

endmodule

// File: rtl/lane_symbol_gen.sv
// rtl/lane_symbol_gen.sv - registered TX symbol pair generator (idle/verify/data, CC when CLK_COMP_EN)
module lane_symbol_gen
  import aurora_pkg::*;
#(
  parameter int A_MIN = 16
`ifdef CLK_COMP_EN
  ,
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 6
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  ordered_sets_t ordered_sets,
  input  logic          init_finished,
  input  logic [15:0]   data_in,
  input  logic          data_valid,
  output logic          data_ready,
  output logic [15:0]   tx_data,
  output logic [1:0]    tx_charisk
);

  state_t      state, next_state;
  logic [15:0] tx_data_d;
  logic [1:0]  tx_charisk_d;
  logic        ready_c;
  logic        adv;
  logic [15:0] idle_sym;
  logic        cc_due;
  logic        cc_active;

  idle_seq_lfsr #(.A_MIN(A_MIN)) u_idle (
    .clk (clk),
    .rst (rst),
    .adv (adv),
    .sym (idle_sym)
  );

`ifdef CLK_COMP_EN
  localparam int CC_W = $clog2(CC_LEN + 1);
  logic [12:0]     cc_timer;
  logic [CC_W-1:0] cc_cnt;

  assign cc_due    = (cc_timer == 13'(CC_PERIOD - 1));
  assign cc_active = (state == S_CC) && (cc_cnt != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc_timer <= 13'd0;
      cc_cnt   <= '0;
    end else begin
      cc_timer <= cc_due ? 13'd0 : cc_timer + 13'd1;
      // cc_cnt holds the burst cycles still owed after the one being emitted.
      if (cc_due)         cc_cnt <= CC_W'(CC_LEN - 1);
      else if (cc_active) cc_cnt <= cc_cnt - 1'b1;
    end
  end
`else
  assign cc_due    = 1'b0;
  assign cc_active = 1'b0;
`endif

  always_comb begin
    next_state   = state;
    tx_data_d    = 16'h0000;
    tx_charisk_d = 2'b00;
    ready_c      = 1'b0;
    adv          = 1'b0;
    if (cc_due || cc_active) begin
      next_state   = S_CC;
      tx_data_d    = sym_pair(K23_7);
      tx_charisk_d = 2'b11;
    end else if (ordered_sets == OS_VER) begin
      next_state   = S_VER;
      tx_data_d    = {K28_5, D21_5};
      tx_charisk_d = 2'b10;
    end else if (ordered_sets == OS_NONE && init_finished) begin
      next_state = S_DATA;
      ready_c    = 1'b1;
      if (data_valid) begin
        tx_data_d    = data_in;
        tx_charisk_d = 2'b00;
      end else begin
        adv          = 1'b1;
        tx_data_d    = idle_sym;
        tx_charisk_d = 2'b11;
      end
    end else begin
      next_state   = S_IDLE;
      adv          = 1'b1;
      tx_data_d    = idle_sym;
      tx_charisk_d = 2'b11;
    end
  end

  assign data_ready = ready_c & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_RESET;
      tx_data    <= 16'h0000;
      tx_charisk <= 2'b00;
    end else begin
      state      <= next_state;
      tx_data    <= tx_data_d;
      tx_charisk <= tx_charisk_d;
    end
  end

endmodule

// File: tb/tb_lane_symbol_gen.sv
// tb/tb_lane_symbol_gen.sv - vector table + scoreboard bench for lane_symbol_gen
module tb_lane_symbol_gen;
  import aurora_pkg::*;

  typedef struct {
    ordered_sets_t os;
    logic          init;
    logic [15:0]   din;
    logic          dv;
    logic          exp_ready;
    logic          idle;
    logic [15:0]   exp_data;
    logic [1:0]    exp_k;
  } vec_t;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  k;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  ordered_sets_t os;
  logic          init;
  logic [15:0]   din;
  logic          dv;
  logic          data_ready;
  logic [15:0]   tx_data;
  logic [1:0]    tx_charisk;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  logic [6:0] m_lfsr;
  int   m_acnt;

  lane_symbol_gen #(
    .A_MIN(16)
`ifdef CLK_COMP_EN
    ,
    .CC_PERIOD(20),
    .CC_LEN(6)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ordered_sets  (os),
    .init_finished (init),
    .data_in       (din),
    .data_valid    (dv),
    .data_ready    (data_ready),
    .tx_data       (tx_data),
    .tx_charisk    (tx_charisk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] model_idle();
    logic [15:0] s;
    if (m_acnt == 0) begin
      s = 16'h7C7C;
      m_acnt = 16 + int'(m_lfsr[3:0]);
    end else begin
      m_acnt--;
      s = m_lfsr[0] ? 16'h1C1C : 16'hBCBC;
    end
    m_lfsr = {m_lfsr[5:0], m_lfsr[6] ^ m_lfsr[5]};
    return s;
  endfunction

  // Drive one cycle of stimulus at posedge+1, then compare the registered output at the next posedge+1.
  task automatic drive(input vec_t v);
    exp_t e, g;
    os = v.os; init = v.init; din = v.din; dv = v.dv;
    #1;
    chk("data_ready", int'(data_ready), int'(v.exp_ready));
    if (v.idle) begin
      e.d = model_idle();
      e.k = 2'b11;
    end else begin
      e.d = v.exp_data;
      e.k = v.exp_k;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1, 0);
    end else begin
      g = sb.pop_front();
      chk("tx_data", int'(tx_data), int'(g.d));
      chk("tx_charisk", int'(tx_charisk), int'(g.k));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; os = OS_IDLE; init = 1'b0; din = 16'h0; dv = 1'b0;
    sb.delete();
    m_lfsr = 7'h5A;
    m_acnt = 16;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_tx_data", int'(tx_data), 0);
    chk("rst_tx_charisk", int'(tx_charisk), 0);
    chk("rst_data_ready", int'(data_ready), 0);
    rst = 1'b0;
  endtask

  vec_t tbl[18];
  vec_t idle_v;

  initial begin
    int since_a;
    int n_a;
    idle_v = '{OS_IDLE, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 2'b11};
    for (int i = 0; i < 10; i++) tbl[i] = '{OS_VER, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'hBCB5, 2'b10};
    tbl[10] = '{OS_NONE, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h1234, 2'b00};
    tbl[11] = '{OS_NONE, 1'b1, 16'h5678, 1'b1, 1'b1, 1'b0, 16'h5678, 2'b00};
    tbl[12] = '{OS_NONE, 1'b1, 16'h9ABC, 1'b1, 1'b1, 1'b0, 16'h9ABC, 2'b00};
    tbl[13] = '{OS_IDLE, 1'b1, 16'hDEAD, 1'b1, 1'b0, 1'b1, 16'h0, 2'b11};
    tbl[14] = '{OS_NONE, 1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b1, 16'h0, 2'b11};
    tbl[15] = '{OS_NONE, 1'b0, 16'hCAFE, 1'b1, 1'b0, 1'b1, 16'h0, 2'b11};
    tbl[16] = '{OS_NONE, 1'b1, 16'h0F0F, 1'b1, 1'b1, 1'b0, 16'h0F0F, 2'b00};
    tbl[17] = '{OS_VER, 1'b1, 16'h1111, 1'b1, 1'b0, 1'b0, 16'hBCB5, 2'b10};

    @(posedge clk); #1;
    do_reset();

    since_a = 0;
    n_a = 0;
    for (int i = 0; i < 110; i++) begin
      drive(idle_v);
      if (i == 0) chk("first_not_a", int'(tx_data != 16'h7C7C && tx_charisk == 2'b11), 1);
      if (tx_data == 16'h7C7C) begin
        if (n_a == 0) chk("first_a_gap", since_a, 16);
        else          chk("a_gap_range", int'(since_a >= 16 && since_a <= 31), 1);
        n_a++;
        since_a = 0;
      end else begin
        since_a++;
      end
    end
    chk("a_seen", int'(n_a >= 3), 1);

    for (int i = 0; i < 18; i++) drive(tbl[i]);

    // Async reset in the middle of a data burst.
    drive(tbl[10]);
    os = OS_NONE; init = 1'b1; din = 16'h4242; dv = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("async_rst_tx_data", int'(tx_data), 0);
    chk("async_rst_charisk", int'(tx_charisk), 0);
    chk("async_rst_ready", int'(data_ready), 0);
    @(posedge clk); #1;
    do_reset();
    drive(idle_v);
    chk("post_rst_first_k", int'(tx_data), 16'hBCBC);
    for (int i = 0; i < 20; i++) drive(idle_v);

`ifdef CLK_COMP_EN
    begin
      logic [15:0] dq[$];
      int beat, first_drop, low, f7;
      do_reset();
      beat = 0; first_drop = -1; low = 0; f7 = 0;
      for (int i = 0; i < 34; i++) begin
        os = OS_NONE; init = 1'b1; din = 16'hC000 + 16'(beat); dv = 1'b1;
        #1;
        if (data_ready) begin
          dq.push_back(din);
          beat++;
        end else begin
          low++;
          if (first_drop < 0) first_drop = i;
        end
        @(posedge clk); #1;
        if (tx_data == 16'hF7F7) begin
          chk("cc_charisk", int'(tx_charisk), 2'b11);
          f7++;
        end else if (dq.size() == 0) begin
          chk("cc_unexpected_data", int'(tx_data), 0);
        end else begin
          chk("cc_data", int'(tx_data), int'(dq.pop_front()));
          chk("cc_data_k", int'(tx_charisk), 0);
        end
      end
      chk("cc_first_drop", first_drop, 19);
      chk("cc_ready_low", low, 6);
      chk("cc_f7_count", f7, 6);
      chk("cc_beats_lost", dq.size(), 0);
      chk("cc_beats", beat, 28);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
